// File: rtl/apb_manager.sv
// apb_manager: converts a valid/ready request stream into APB SETUP/ACCESS
// transfers, with one-hot select decode, a wait-state timeout and exactly one
// response pulse per accepted request.
//
// Ports:
//   clk, nReset                  clock, synchronous active-low reset
//   req_valid/req_ready          request handshake (req_ready is combinational)
//   req_write/addr/wdata/strb/prot  request payload
//   rsp_valid/rsp_rdata/rsp_error   one-cycle response
//   addr/selectors/enable/write/wData/strb/prot  APB manager outputs
//   ready/rData/subError         APB subordinate inputs
module apb_manager #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumSubs       = 4,
    parameter int unsigned SelLsb        = 12,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AddrWidth-1:0]     req_addr,
    input  logic [DataWidth-1:0]     req_wdata,
    input  logic [DataWidth/8-1:0]   req_strb,
    input  logic [2:0]               req_prot,
    output logic                     rsp_valid,
    output logic [DataWidth-1:0]     rsp_rdata,
    output logic                     rsp_error,
    output logic [AddrWidth-1:0]     addr,
    output logic [NumSubs-1:0]       selectors,
    output logic                     enable,
    output logic                     write,
    output logic [DataWidth-1:0]     wData,
    output logic [DataWidth/8-1:0]   strb,
    output logic [2:0]               prot,
    input  logic                     ready,
    input  logic [DataWidth-1:0]     rData,
    input  logic                     subError
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned SelW  = (NumSubs > 1) ? $clog2(NumSubs) : 1;
    localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_run;      // low only on the cycle after a reset edge
    logic                   r_pend;     // decode error waiting behind a transfer response
    logic [CntW-1:0]        r_cnt;
    logic                   r_rsp_valid;
    logic [DataWidth-1:0]   r_rsp_rdata;
    logic                   r_rsp_error;
    logic [AddrWidth-1:0]   r_addr;
    logic [NumSubs-1:0]     r_sel;
    logic                   r_enable;
    logic                   r_write;
    logic [DataWidth-1:0]   r_wdata;
    logic [StrbW-1:0]       r_strb;
    logic [2:0]             r_prot;

    logic [SelW-1:0]        w_idx;
    logic                   w_idx_ok;
    logic [NumSubs-1:0]     w_sel;
    logic                   w_timeout;
    logic                   w_done;
    logic                   w_req_ready;
    logic                   w_hs;
    logic [DataWidth-1:0]   w_wdata;
    logic [StrbW-1:0]       w_strb;

    // Request decode and handshake
    assign w_idx       = req_addr[SelLsb +: SelW];
    assign w_idx_ok    = (32'(w_idx) < NumSubs);
    assign w_sel       = NumSubs'(1) << w_idx;
    assign w_wdata     = req_write ? req_wdata : '0;
    assign w_strb      = req_write ? req_strb  : '0;
    assign w_timeout   = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles - 1)) && !ready;
    assign w_done      = (r_state == S_ACCESS) && (ready || w_timeout);
    assign w_req_ready = r_run && ((r_state == S_IDLE) || w_done);
    assign w_hs        = req_valid && w_req_ready;

    // Transfer FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_pend      <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_addr      <= '0;
            r_sel       <= '0;
            r_enable    <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_prot      <= '0;
        end else begin
            r_run       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A deferred decode error goes out first; a new one queues behind it.
                    r_rsp_valid <= r_pend;
                    r_rsp_error <= r_pend;
                    r_pend      <= 1'b0;
                    if (w_hs) begin
                        if (w_idx_ok) begin
                            r_addr  <= req_addr;
                            r_write <= req_write;
                            r_wdata <= w_wdata;
                            r_strb  <= w_strb;
                            r_prot  <= req_prot;
                            r_sel   <= w_sel;
                            r_state <= S_SETUP;
                        end else if (r_pend) begin
                            r_pend <= 1'b1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    r_enable <= 1'b1;
                    r_state  <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!ready) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                    if (w_done) begin
                        r_cnt       <= '0;
                        r_enable    <= 1'b0;
                        r_sel       <= '0;
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        if (ready) begin
                            r_rsp_error <= subError;
                            r_rsp_rdata <= r_write ? '0 : rData;
                        end else begin
                            r_rsp_error <= 1'b1;
                        end
                        // Back-to-back request skips the IDLE bubble
                        if (w_hs) begin
                            if (w_idx_ok) begin
                                r_addr   <= req_addr;
                                r_write  <= req_write;
                                r_wdata  <= w_wdata;
                                r_strb   <= w_strb;
                                r_prot   <= req_prot;
                                r_sel    <= w_sel;
                                r_enable <= 1'b0;
                                r_state  <= S_SETUP;
                            end else begin
                                r_pend <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign addr      = r_addr;
    assign selectors = r_sel;
    assign enable    = r_enable;
    assign write     = r_write;
    assign wData     = r_wdata;
    assign strb      = r_strb;
    assign prot      = r_prot;

endmodule

// File: tb/tb_apb_manager.sv
// Scoreboard bench for apb_manager: a 4-subordinate instance for transfers,
// timeout and reset abort, and a 3-subordinate instance for decode errors.
module tb_apb_manager;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    // Instance A: NumSubs = 4
    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_strb;
    logic [2:0]  a_req_prot;
    logic        a_rsp_valid, a_rsp_error;
    logic [31:0] a_rsp_rdata, a_addr, a_wdata, a_rdata;
    logic [3:0]  a_sel, a_strb;
    logic        a_enable, a_write, a_ready, a_suberr;
    logic [2:0]  a_prot;

    // Instance B: NumSubs = 3
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_strb;
    logic [2:0]  b_req_prot;
    logic        b_rsp_valid, b_rsp_error;
    logic [31:0] b_rsp_rdata, b_addr, b_wdata, b_rdata;
    logic [2:0]  b_sel;
    logic [3:0]  b_strb;
    logic        b_enable, b_write, b_ready, b_suberr;
    logic [2:0]  b_prot;

    apb_manager #(.NumSubs(4)) dut_a (
        .clk(clk), .nReset(nReset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_strb(a_req_strb),
        .req_prot(a_req_prot), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_error(a_rsp_error), .addr(a_addr), .selectors(a_sel), .enable(a_enable),
        .write(a_write), .wData(a_wdata), .strb(a_strb), .prot(a_prot),
        .ready(a_ready), .rData(a_rdata), .subError(a_suberr)
    );

    apb_manager #(.NumSubs(3)) dut_b (
        .clk(clk), .nReset(nReset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb),
        .req_prot(b_req_prot), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_error(b_rsp_error), .addr(b_addr), .selectors(b_sel), .enable(b_enable),
        .write(b_write), .wData(b_wdata), .strb(b_strb), .prot(b_prot),
        .ready(b_ready), .rData(b_rdata), .subError(b_suberr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitors: pop expected entry whenever a response appears
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (a_rsp_valid === 1'b1) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = qa.pop_front();
                    chk("a_rsp_rdata", a_rsp_rdata, e.rdata);
                    chk("a_rsp_error", 32'(a_rsp_error), 32'(e.err));
                    chk("a_rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                checks++;
                if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_error !== 1'b0) begin
                    errors++;
                    $display("FAIL a_rsp_idle: got valid=%b rdata=%h err=%b expected all 0", a_rsp_valid, a_rsp_rdata, a_rsp_error);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (b_rsp_valid === 1'b1) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = qb.pop_front();
                    chk("b_rsp_rdata", b_rsp_rdata, e.rdata);
                    chk("b_rsp_error", 32'(b_rsp_error), 32'(e.err));
                    chk("b_rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                checks++;
                if (b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0 || b_rsp_error !== 1'b0) begin
                    errors++;
                    $display("FAIL b_rsp_idle: got valid=%b rdata=%h err=%b expected all 0", b_rsp_valid, b_rsp_rdata, b_rsp_error);
                end
            end
        end
    end

    // Present a request on A, wait (bounded) for the handshake, push expectation
    task automatic a_send(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] er, input logic ee,
                          input int lat, input bit push, output int t);
        a_req_valid = 1'b1; a_req_write = w; a_req_addr = ad;
        a_req_wdata = wd;   a_req_strb = st; a_req_prot = 3'b010;
        t = -1;
        for (int i = 0; i < 64 && t < 0; i++) begin
            @(negedge clk);
            if (a_req_ready === 1'b1) t = cyc;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL a_handshake: got no req_ready expected handshake within 64 cycles");
        end else if (push) begin
            qa.push_back('{er, ee, t + 3 + lat});
        end
    endtask

    task automatic b_send(input logic [31:0] ad, input logic [31:0] er, input logic ee,
                          input int lat, output int t);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = ad;
        b_req_wdata = 32'h0; b_req_strb = 4'h0; b_req_prot = 3'b000;
        t = -1;
        for (int i = 0; i < 64 && t < 0; i++) begin
            @(negedge clk);
            if (b_req_ready === 1'b1) t = cyc;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL b_handshake: got no req_ready expected handshake within 64 cycles");
        end else begin
            qb.push_back('{er, ee, t + 3 + lat});
        end
    endtask

    initial begin
        int t, t1, t2;
        nReset = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_strb = 0; a_req_prot = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_strb = 0; b_req_prot = 0;
        a_ready = 1'b1; a_rdata = 32'h5555_5555; a_suberr = 1'b0;
        b_ready = 1'b1; b_rdata = 32'h0BAD_F00D; b_suberr = 1'b0;

        // Reset held for three edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_reset_req_ready", 32'(a_req_ready), 32'h0);
        @(posedge clk); #1;
        nReset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'h1);
        chk("rst_selectors", 32'(a_sel), 32'h0);
        chk("rst_enable", 32'(a_enable), 32'h0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_wdata", a_wdata, 32'h0);
        chk("rst_strb", 32'(a_strb), 32'h0);
        chk("rst_write", 32'(a_write), 32'h0);
        chk("rst_prot", 32'(a_prot), 32'h0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'h1);

        // Zero-wait write; rData is nonzero but write response data must be 0
        @(posedge clk); #1;
        a_send(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0, 1'b1, t);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("wr_setup_sel", 32'(a_sel), 32'h4);
        chk("wr_setup_enable", 32'(a_enable), 32'h0);
        chk("wr_setup_addr", a_addr, 32'h0000_2010);
        chk("wr_setup_wdata", a_wdata, 32'hDEAD_BEEF);
        chk("wr_setup_strb", 32'(a_strb), 32'hF);
        chk("wr_setup_write", 32'(a_write), 32'h1);
        chk("wr_setup_prot", 32'(a_prot), 32'h2);
        @(negedge clk);
        chk("wr_access_sel", 32'(a_sel), 32'h4);
        chk("wr_access_enable", 32'(a_enable), 32'h1);
        @(negedge clk);
        chk("wr_done_sel", 32'(a_sel), 32'h0);
        chk("wr_done_enable", 32'(a_enable), 32'h0);

        // Read with three wait states and subordinate error; wdata/strb masked
        @(posedge clk); #1;
        a_ready = 1'b0;
        a_send(1'b0, 32'h0000_1004, 32'hAAAA_5555, 4'hF, 32'h1234_5678, 1'b1, 3, 1'b1, t);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("rd_setup_sel", 32'(a_sel), 32'h2);
        chk("rd_strb_masked", 32'(a_strb), 32'h0);
        chk("rd_wdata_masked", a_wdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_wait_enable", 32'(a_enable), 32'h1);
            chk("rd_wait_strb", 32'(a_strb), 32'h0);
        end
        @(posedge clk); #1;
        a_ready = 1'b1; a_rdata = 32'h1234_5678; a_suberr = 1'b1;
        @(posedge clk); #1;
        a_suberr = 1'b0; a_rdata = 32'hCAFE_F00D;

        // Back-to-back reads: second accepted in the completing ACCESS cycle
        a_send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b1, t1);
        @(posedge clk); #1;
        a_send(1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b1, t2);
        chk("b2b_hs_cycle", 32'(t2), 32'(t1 + 2));
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_setup_sel", 32'(a_sel), 32'h8);
        chk("b2b_setup_enable", 32'(a_enable), 32'h0);
        chk("b2b_setup_addr", a_addr, 32'h0000_3000);

        // Timeout: ready never rises, abort after 16 ACCESS cycles
        repeat (4) @(posedge clk);
        #1;
        a_ready = 1'b0; a_rdata = 32'hFFFF_FFFF;
        a_send(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 15, 1'b1, t);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        repeat (16) @(negedge clk);
        @(negedge clk);
        chk("to_last_access_enable", 32'(a_enable), 32'h1);
        chk("to_last_access_sel", 32'(a_sel), 32'h1);
        @(negedge clk);
        chk("to_after_enable", 32'(a_enable), 32'h0);
        chk("to_after_sel", 32'(a_sel), 32'h0);
        @(posedge clk); #1;
        a_ready = 1'b1;

        // Reset during ACCESS: bus drops, no response
        repeat (2) @(posedge clk);
        #1;
        a_ready = 1'b0;
        a_send(1'b1, 32'h0000_2000, 32'h1, 4'hF, 32'h0, 1'b0, 0, 1'b0, t);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pre_enable", 32'(a_enable), 32'h1);
        @(posedge clk); #1;
        nReset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_sel", 32'(a_sel), 32'h0);
        chk("abort_enable", 32'(a_enable), 32'h0);
        chk("abort_req_ready", 32'(a_req_ready), 32'h0);
        @(posedge clk); #1;
        nReset = 1'b1;
        a_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_recover_req_ready", 32'(a_req_ready), 32'h1);

        // Decode errors on B: three back-to-back, one response per cycle
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("derr_req_ready", 32'(b_req_ready), 32'h1);
            chk("derr_sel", 32'(b_sel), 32'h0);
            chk("derr_enable", 32'(b_enable), 32'h0);
            qb.push_back('{32'h0, 1'b1, cyc + 1});
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;

        // Decode error accepted on ACCESS completion: error follows the read response
        repeat (2) @(posedge clk);
        #1;
        b_send(32'h0000_1000, 32'h0BAD_F00D, 1'b0, 0, t1);
        @(posedge clk); #1;
        b_send(32'h0000_3000, 32'h0, 1'b1, -1, t2);
        chk("derr_b2b_hs_cycle", 32'(t2), 32'(t1 + 2));
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("derr_b2b_sel", 32'(b_sel), 32'h0);
        chk("derr_b2b_enable", 32'(b_enable), 32'h0);

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000 time units");
        $fatal(1);
    end

endmodule
